// File: rtl/serial_subtractor_pkg.sv
// Shared arithmetic package: default width, FSM states and counter sizing.
package arith_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bit-counter width for a given operand width (at least one bit).
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W_DEFAULT = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(parameter int WIDTH = 4);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;

  modport master (
    output start, A, B,
    input  busy, done, D, Bout
  );

  modport slave (
    input  start, A, B,
    output busy, done, D, Bout
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B, LSB first, one bit per clock through a
// single full-subtractor cell. Result and borrow are registered and held
// until the next completion.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cell_d, cell_bout;

  full_subtractor u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Next-state logic: operand capture, per-bit shifting and completion.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          // Result register D is deliberately left holding the old value.
          a_d      = bus.A;
          b_d      = bus.B;
          r_d      = '0;
          cnt_d    = '0;
          borrow_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end else begin
          state_d  = IDLE;
        end
      end
      SHIFT: begin
        a_d      = {1'b0, a_q[WIDTH-1:1]};
        b_d      = {1'b0, b_q[WIDTH-1:1]};
        r_d      = {cell_d, r_q[WIDTH-1:1]};
        borrow_d = cell_bout;
        if (cnt_q == LAST_CNT) begin
          res_d   = {cell_d, r_q[WIDTH-1:1]};
          bout_d  = cell_bout;
          cnt_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.D    = res_q;
  assign bus.Bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for the bit-serial subtractor.
module tb_serial_subtractor;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   overlap;
  int   done_cnt;

  serial_subtractor_if #(.WIDTH(4)) bus4();
  serial_subtractor_if #(.WIDTH(8)) bus8();

  serial_subtractor #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus4));
  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watch for busy/done overlap and count done pulses of the 4-bit unit.
  always @(negedge clk) begin
    if (bus4.busy && bus4.done) overlap++;
    if (bus8.busy && bus8.done) overlap++;
    if (bus4.done) done_cnt++;
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] d;
    logic       bout;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                       output logic [3:0] d_o, output logic bo_o,
                       output int bcnt, output bit ok);
    bus4.start = 1'b1;
    bus4.A = a;
    bus4.B = b;
    @(negedge clk);
    bus4.start = 1'b0;
    bus4.A = ~a;
    bus4.B = ~b;
    bcnt = 0;
    ok = 1'b0;
    d_o = 4'h0;
    bo_o = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus4.done) begin
        ok = 1'b1;
        d_o = bus4.D;
        bo_o = bus4.Bout;
        break;
      end
      if (bus4.busy) bcnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [3:0] d;
    logic       bo;
    int         bc;
    bit         ok;
    logic [4:0] diff;
    int         dc;

    checks = 0; errors = 0; overlap = 0; done_cnt = 0;
    vecs[0] = '{4'd9,  4'd3,  4'd6,  1'b0};
    vecs[1] = '{4'd3,  4'd9,  4'd10, 1'b1};
    vecs[2] = '{4'd15, 4'd15, 4'd0,  1'b0};
    vecs[3] = '{4'd0,  4'd1,  4'd15, 1'b1};
    vecs[4] = '{4'd1,  4'd0,  4'd1,  1'b0};
    vecs[5] = '{4'd8,  4'd9,  4'd15, 1'b1};
    vecs[6] = '{4'd15, 4'd0,  4'd15, 1'b0};
    vecs[7] = '{4'd5,  4'd12, 4'd9,  1'b1};

    rst = 1'b1;
    bus4.start = 1'b0; bus4.A = 4'h0; bus4.B = 4'h0;
    bus8.start = 1'b0; bus8.A = 8'h00; bus8.B = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", bus4.busy, 1'b0);
    check("rst_done", bus4.done, 1'b0);
    check("rst_d",    bus4.D,    4'h0);
    check("rst_bout", bus4.Bout, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", bus4.busy, 1'b0);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, d, bo, bc, ok);
      check("tbl_done", ok, 1'b1);
      check("tbl_busy_cycles", bc, 4);
      check("tbl_d", d, vecs[i].d);
      check("tbl_bout", bo, vecs[i].bout);
      @(negedge clk);
      check("tbl_done_pulse", bus4.done, 1'b0);
      check("tbl_idle_busy", bus4.busy, 1'b0);
      check("tbl_hold_d", bus4.D, vecs[i].d);
    end

    // Start pulse while busy is ignored.
    dc = done_cnt;
    bus4.start = 1'b1; bus4.A = 4'd12; bus4.B = 4'd5;
    @(negedge clk);
    bus4.start = 1'b0; bus4.A = 4'd0; bus4.B = 4'd0;
    @(negedge clk);
    bus4.start = 1'b1; bus4.A = 4'd1; bus4.B = 4'd1;
    @(negedge clk);
    bus4.start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus4.done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("ign_done", ok, 1'b1);
    check("ign_d", bus4.D, 4'd7);
    check("ign_bout", bus4.Bout, 1'b0);
    for (int i = 0; i < 8; i++) @(negedge clk);
    check("ign_one_done", done_cnt - dc, 1);
    check("ign_idle_busy", bus4.busy, 1'b0);

    // Back-to-back: restart in the DONE cycle.
    do_op(4'd7, 4'd2, d, bo, bc, ok);
    check("b2b_first_done", ok, 1'b1);
    check("b2b_first_d", d, 4'd5);
    check("b2b_first_bout", bo, 1'b0);
    do_op(4'd8, 4'd8, d, bo, bc, ok);
    check("b2b_second_done", ok, 1'b1);
    check("b2b_busy_cycles", bc, 4);
    check("b2b_second_d", d, 4'd0);
    check("b2b_second_bout", bo, 1'b0);
    @(negedge clk);

    // Asynchronous reset in the middle of an operation.
    do_op(4'd15, 4'd0, d, bo, bc, ok);
    check("pre_rst_d", d, 4'd15);
    @(negedge clk);
    bus4.start = 1'b1; bus4.A = 4'd9; bus4.B = 4'd3;
    @(negedge clk);
    bus4.start = 1'b0;
    @(negedge clk);
    check("mid_busy_before_rst", bus4.busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", bus4.busy, 1'b0);
    check("arst_done", bus4.done, 1'b0);
    check("arst_d",    bus4.D,    4'h0);
    check("arst_bout", bus4.Bout, 1'b0);
    dc = done_cnt;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);
    check("arst_no_done", done_cnt - dc, 0);
    do_op(4'd6, 4'd2, d, bo, bc, ok);
    check("post_rst_done", ok, 1'b1);
    check("post_rst_d", d, 4'd4);
    check("post_rst_bout", bo, 1'b0);
    @(negedge clk);

    // Exhaustive 4-bit sweep against a 5-bit reference subtraction.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        diff = {1'b0, 4'(a)} - {1'b0, 4'(b)};
        do_op(4'(a), 4'(b), d, bo, bc, ok);
        check("sweep_done", ok, 1'b1);
        check("sweep_d", d, diff[3:0]);
        check("sweep_bout", bo, (a < b) ? 1'b1 : 1'b0);
        @(negedge clk);
      end
    end

    // 8-bit spot check.
    bus8.start = 1'b1; bus8.A = 8'h00; bus8.B = 8'h01;
    @(negedge clk);
    bus8.start = 1'b0; bus8.A = 8'h55; bus8.B = 8'hAA;
    bc = 0; ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus8.done) begin ok = 1'b1; break; end
      if (bus8.busy) bc++;
      @(negedge clk);
    end
    check("w8_done", ok, 1'b1);
    check("w8_busy_cycles", bc, 8);
    check("w8_d", bus8.D, 8'hFF);
    check("w8_bout", bus8.Bout, 1'b1);
    @(negedge clk);

    check("no_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor. Computes D = A - B and borrow-out Bout, LSB first, one bit per clock.
- Built around a single one-bit full-subtractor cell.
- Inverse-direction companion to the team's combinational ripple-carry adder blocks. Used where area matters more than latency.
- Operands are captured on a start handshake. Result is flagged by a one-cycle done pulse.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..16).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin a subtraction. Sampled only in IDLE or DONE.
- A  input  WIDTH  minuend. Captured on an accepted start.
- B  input  WIDTH  subtrahend. Captured on an accepted start.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  one-cycle pulse; D and Bout are valid from this cycle.
- D  output  WIDTH  difference, A - B modulo 2^WIDTH.
- Bout  output  1  borrow out; 1 when A < B (unsigned).

Behaviour:
- Reset (asynchronous, rst=1) forces the following immediately, with no clock needed:
  - state=IDLE; busy=0; done=0; D=0; Bout=0.
  - Internal operand shift registers, borrow flop and bit counter all cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at a rising edge: load A and B into shift registers, clear borrow flop, counter=0, go to SHIFT.
  - busy=1 from the following cycle.
  - start=0: remain in IDLE.
- SHIFT, at each edge:
  - Cell computes d = a0 ^ b0 ^ bin and bout = (~a0 & b0) | (~(a0 ^ b0) & bin).
  - a0, b0 are the LSBs of the operand registers; bin is the borrow flop.
  - d shifts into the MSB of the result register (right shift).
  - Operand registers shift right; borrow flop <= bout; counter increments.
  - When counter reaches WIDTH-1 at an edge, that edge processes the final bit, then:
    - D <= completed result; Bout <= final bout.
    - state <= DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - Next edge goes to IDLE, or to SHIFT if start=1 in that cycle (back-to-back operation, operands re-captured).
- Latency: start sampled at edge E0 → done high in the cycle after edge E0+WIDTH.
  - Throughput is one result per WIDTH+1 cycles.
- D and Bout update only on the final SHIFT edge. They hold their value through DONE and IDLE until the next completion.
  - D is not cleared when a new operation starts.
- start while busy=1 (SHIFT) is ignored. The operation in flight is unaffected.
- A and B may change freely after the capture edge. They have no effect until the next accepted start.
- Arithmetic is unsigned modulo 2^WIDTH. A < B gives the two's-complement wrap with Bout=1; A == B gives D=0, Bout=0.
- rst asserted mid-operation aborts immediately:
  - All outputs return to reset values; no done pulse.
  - First start after rst deasserts is accepted normally.
- Invariant: busy and done are never high in the same cycle.

Decomposition:
- Shared package (arith_pkg):
  - Default WIDTH constant.
  - FSM state enumeration (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - Counter width constant, $clog2(WIDTH).
- Sub-module full_subtractor:
  - Purely combinational.
  - Ports: a, b, bin, d, bout.
  - Instantiated once. Reused by the later combinational ripple-borrow subtractor.

Test Plan:
1. Reset then start with A=9, B=3 (WIDTH=4):
   - busy high for 4 cycles.
   - done pulses one cycle later with D=6, Bout=0.
   - busy and done never overlap.
2. A=3, B=9 → D=10 (0xA), Bout=1. Then A=15, B=15 → D=0, Bout=0. Then A=0, B=1 → D=15, Bout=1.
3. Start A=12, B=5; pulse start with A=1, B=1 during cycle 2 of SHIFT:
   - Second request ignored.
   - Result D=7, Bout=0.
   - No extra done pulse.
4. Back-to-back:
   - Hold start=1 in the DONE cycle with new A=8, B=8.
   - Second operation begins without an IDLE cycle; second done gives D=0, Bout=0.
   - First result (e.g. A=7, B=2 → D=5) visible in the first done cycle.
5. Reset mid-operation:
   - Assert rst asynchronously (between edges) in SHIFT cycle 2.
   - Outputs go to 0 before the next edge; no done pulse.
   - After release, A=6, B=2 gives D=4.
6. Exhaustive sweep: all 256 (A, B) pairs for WIDTH=4, checked against a reference model of (A - B) mod 16 and A < B.
   - Plus a spot check with WIDTH=8: A=0x00, B=0x01 → D=0xFF, Bout=1.
